// File: rtl/uart_echo_ctrl.sv
// Loopback controller: pops a word from the UART RX FIFO and pushes it to the TX FIFO.
// Optional ASCII lower-to-upper transform when UART_ECHO_UPCASE_EN is defined.
//
// state  | meaning
// IDLE   | waiting for enable and a non-empty RX FIFO
// HOLD   | word popped, waiting for TX space (or stall timeout)
// PUSH   | push strobe issued, returning to IDLE
module uart_echo_ctrl #(
    parameter int DBIT    = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 0,
    parameter int TO_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              rx_empty,
    input  logic [DBIT-1:0]   r_data,
    input  logic              tx_full,
    output logic              rd_uart,
    output logic              wr_uart,
    output logic [DBIT-1:0]   w_data,
    output logic              o_busy,
    output logic              o_drop,
    output logic [CNT_W-1:0]  o_echo_cnt,
    output logic [CNT_W-1:0]  o_drop_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_PUSH = 2'd2;

    logic [1:0]       r_state;
    logic [DBIT-1:0]  r_data_reg;
    logic [TO_W-1:0]  r_stall;
    logic             r_rd;
    logic             r_wr;
    logic [DBIT-1:0]  r_w_data;
    logic             r_busy;
    logic             r_drop;
    logic [CNT_W-1:0] r_echo_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [DBIT-1:0]  w_xform;
    logic             w_stall_hit;

`ifdef UART_ECHO_UPCASE_EN
    localparam logic [DBIT-1:0] LC_LO    = DBIT'(32'h61);
    localparam logic [DBIT-1:0] LC_HI    = DBIT'(32'h7A);
    localparam logic [DBIT-1:0] CASE_BIT = DBIT'(32'h20);

    always_comb begin
        w_xform = r_data_reg;
        if (DBIT == 8) begin
            if (r_data_reg >= LC_LO && r_data_reg <= LC_HI)
                w_xform = r_data_reg & ~CASE_BIT;
        end
    end
`else
    always_comb begin
        w_xform = r_data_reg;
    end
`endif

    // TIMEOUT of zero disables dropping entirely.
    assign w_stall_hit = (TIMEOUT > 0) && (r_stall == TO_W'(TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_data_reg <= '0;
            r_stall    <= '0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_w_data   <= '0;
            r_busy     <= 1'b0;
            r_drop     <= 1'b0;
            r_echo_cnt <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_rd   <= 1'b0;
            r_wr   <= 1'b0;
            r_drop <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_enable && !rx_empty) begin
                        r_data_reg <= r_data;
                        r_rd       <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!tx_full) begin
                        r_w_data   <= w_xform;
                        r_wr       <= 1'b1;
                        r_echo_cnt <= r_echo_cnt + 1'b1;
                        r_stall    <= '0;
                        r_state    <= S_PUSH;
                    end else if (w_stall_hit) begin
                        r_drop     <= 1'b1;
                        r_drop_cnt <= r_drop_cnt + 1'b1;
                        r_stall    <= '0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_stall <= r_stall + 1'b1;
                    end
                end
                S_PUSH: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_uart    = r_rd;
    assign wr_uart    = r_wr;
    assign w_data     = r_w_data;
    assign o_busy     = r_busy;
    assign o_drop     = r_drop;
    assign o_echo_cnt = r_echo_cnt;
    assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Directed bench for uart_echo_ctrl: one instance never drops, a second drops after 5 stalled cycles.
module tb_uart_echo_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic        rx_empty;
    logic [7:0]  r_data;
    logic        tx_full;

    logic        rd_a, wr_a, busy_a, drop_a;
    logic [7:0]  wdata_a;
    logic [15:0] echo_a, dcnt_a;
    logic        rd_b, wr_b, busy_b, drop_b;
    logic [7:0]  wdata_b;
    logic [15:0] echo_b, dcnt_b;

    int n_total = 0;
    int n_bad   = 0;

    always #5 i_clk = ~i_clk;

    uart_echo_ctrl #(.DBIT(8), .CNT_W(16), .TIMEOUT(0), .TO_W(16)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .rx_empty(rx_empty),
        .r_data(r_data), .tx_full(tx_full), .rd_uart(rd_a), .wr_uart(wr_a),
        .w_data(wdata_a), .o_busy(busy_a), .o_drop(drop_a),
        .o_echo_cnt(echo_a), .o_drop_cnt(dcnt_a)
    );

    uart_echo_ctrl #(.DBIT(8), .CNT_W(16), .TIMEOUT(5), .TO_W(16)) dut_to (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .rx_empty(rx_empty),
        .r_data(r_data), .tx_full(tx_full), .rd_uart(rd_b), .wr_uart(wr_b),
        .w_data(wdata_b), .o_busy(busy_b), .o_drop(drop_b),
        .o_echo_cnt(echo_b), .o_drop_cnt(dcnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset  = 1'b1;
        i_enable = 1'b1;
        rx_empty = 1'b1;
        r_data   = 8'h00;
        tx_full  = 1'b0;
        tick();
        tick();
        i_reset = 1'b0;
    endtask

    function automatic logic [7:0] xf(input logic [7:0] d);
`ifdef UART_ECHO_UPCASE_EN
        if (d >= 8'h61 && d <= 8'h7A) return d & 8'hDF;
`endif
        return d;
    endfunction

    // Single word with free TX: pop strobe, then push strobe on the next edge.
    task automatic echo_one(input string tag, input logic [7:0] d, input logic [7:0] exp_w);
        rx_empty = 1'b0;
        r_data   = d;
        tx_full  = 1'b0;
        tick();
        chk({tag, "_rd"}, rd_a, 1);
        rx_empty = 1'b1;
        tick();
        chk({tag, "_wr"}, wr_a, 1);
        chk({tag, "_wdata"}, wdata_a, exp_w);
        tick();
        chk({tag, "_idle"}, busy_a, 0);
    endtask

    logic [7:0] words [4];
    int idx;
    int rd_cyc [$];
    int wr_cyc [$];
    logic [7:0] wr_dat [$];
    int overlap;

    initial begin
        // reset state
        i_reset = 1'b1; i_enable = 1'b0; rx_empty = 1'b0; r_data = 8'hFF; tx_full = 1'b0;
        tick();
        tick();
        chk("rst_rd", rd_a, 0);
        chk("rst_wr", wr_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_wdata", wdata_a, 0);
        chk("rst_echo", echo_a, 0);
        chk("rst_drop", dcnt_a, 0);

        // single word 8'h41
        do_reset();
        rx_empty = 1'b0; r_data = 8'h41;
        tick();
        chk("t1_rd", rd_a, 1);
        chk("t1_busy", busy_a, 1);
        chk("t1_wr_early", wr_a, 0);
        rx_empty = 1'b1;
        tick();
        chk("t1_rd_off", rd_a, 0);
        chk("t1_wr", wr_a, 1);
        chk("t1_wdata", wdata_a, 8'h41);
        chk("t1_echo", echo_a, 1);
        tick();
        chk("t1_wr_off", wr_a, 0);
        chk("t1_busy_off", busy_a, 0);
        chk("t1_hold_wdata", wdata_a, 8'h41);

        // burst of four words from a FIFO model that advances on each pop
        do_reset();
        words[0] = 8'h10; words[1] = 8'h22; words[2] = 8'h3C; words[3] = 8'h4F;
        idx = 0; overlap = 0;
        for (int c = 0; c < 16; c++) begin
            rx_empty = (idx >= 4);
            r_data   = (idx < 4) ? words[idx] : 8'h00;
            tick();
            if (rd_a && wr_a) overlap++;
            if (rd_a) begin rd_cyc.push_back(c); idx++; end
            if (wr_a) begin wr_cyc.push_back(c); wr_dat.push_back(wdata_a); end
        end
        rx_empty = 1'b1;
        chk("t2_npop", rd_cyc.size(), 4);
        chk("t2_npush", wr_cyc.size(), 4);
        chk("t2_overlap", overlap, 0);
        chk("t2_echo", echo_a, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < rd_cyc.size() && k < wr_cyc.size()) begin
                chk($sformatf("t2_lat%0d", k), wr_cyc[k] - rd_cyc[k], 1);
                chk($sformatf("t2_dat%0d", k), wr_dat[k], words[k]);
                if (k > 0) chk($sformatf("t2_gap%0d", k), rd_cyc[k] - rd_cyc[k-1], 3);
            end
        end

        // stall timeout on the TIMEOUT=5 instance
        do_reset();
        rx_empty = 1'b0; r_data = 8'h33; tx_full = 1'b1;
        tick();
        chk("t3_rd", rd_b, 1);
        rx_empty = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("t3_nodrop%0d", k), drop_b, 0);
            chk($sformatf("t3_nowr%0d", k), wr_b, 0);
        end
        tick();
        chk("t3_drop", drop_b, 1);
        chk("t3_dcnt", dcnt_b, 1);
        chk("t3_wr", wr_b, 0);
        chk("t3_echo", echo_b, 0);
        tick();
        chk("t3_drop_off", drop_b, 0);
        chk("t3_idle", busy_b, 0);
        chk("t3_nodrop_inst", drop_a, 0);
        chk("t3_hold_inst", busy_a, 1);

        // TX full for three cycles, then free (never-drop instance)
        do_reset();
        rx_empty = 1'b0; r_data = 8'h5A; tx_full = 1'b1;
        tick();
        chk("t4_rd", rd_a, 1);
        rx_empty = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t4_nowr%0d", k), wr_a, 0);
        end
        tx_full = 1'b0;
        tick();
        chk("t4_wr", wr_a, 1);
        chk("t4_wdata", wdata_a, 8'h5A);
        chk("t4_drop", dcnt_a, 0);
        chk("t4_echo", echo_a, 1);

        // enable gating
        do_reset();
        i_enable = 1'b0; rx_empty = 1'b0; r_data = 8'h77;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t5_norPOP%0d", k), rd_a, 0);
        end
        i_enable = 1'b1;
        tick();
        chk("t5_rd", rd_a, 1);
        i_enable = 1'b0;
        tick();
        chk("t5_wr", wr_a, 1);
        chk("t5_wdata", wdata_a, xf(8'h77));
        tick();
        chk("t5_busy_off", busy_a, 0);
        tick();
        chk("t5_no_next", rd_a, 0);
        chk("t5_echo", echo_a, 1);

        // reset while holding a popped word
        i_enable = 1'b1; tx_full = 1'b1;
        tick();
        chk("t5r_rd", rd_a, 1);
        i_reset = 1'b1; tx_full = 1'b0;
        tick();
        chk("t5r_rd", rd_a, 0);
        chk("t5r_wr", wr_a, 0);
        chk("t5r_busy", busy_a, 0);
        chk("t5r_wdata", wdata_a, 0);
        chk("t5r_echo", echo_a, 0);
        i_reset = 1'b0; rx_empty = 1'b1;
        tick();
        chk("t5r_nopush", wr_a, 0);

        // optional case transform
        do_reset();
`ifdef UART_ECHO_UPCASE_EN
        echo_one("t6a", 8'h61, 8'h41);
        echo_one("t6b", 8'h7A, 8'h5A);
`else
        echo_one("t6a", 8'h61, 8'h61);
        echo_one("t6b", 8'h7A, 8'h7A);
`endif
        echo_one("t6c", 8'h5B, 8'h5B);
        chk("t6_echo", echo_a, 3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
